// File: rtl/reg_demux.sv
// reg_demux: registered 1-to-2 demultiplexer with valid/ready handshakes.
// Each input word is steered by sel into a one-entry holding register on
// port A or port B. Each port keeps its word until its own consumer takes
// it, so a stalled port never blocks words bound for the other port.
// Each port also counts its completed deliveries; the counter wraps silently.
module reg_demux #(
    parameter int SIZE  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_data,
    input  logic             sel,

    output logic             a_valid,
    input  logic             a_ready,
    output logic [SIZE-1:0]  a_data,
    output logic [CNT_W-1:0] a_count,

    output logic             b_valid,
    input  logic             b_ready,
    output logic [SIZE-1:0]  b_data,
    output logic [CNT_W-1:0] b_count
);

    logic a_fire;
    logic b_fire;
    logic in_fire;
    logic a_load;
    logic b_load;
    logic tgt_free;

    // Accept when the targeted port is empty or is emptying this same cycle.
    // A word offered during reset is not accepted.
    always_comb begin
        tgt_free = sel ? (!b_valid || b_ready) : (!a_valid || a_ready);
        in_ready = !rst && tgt_free;
    end

    // Handshake decode. Only the port named by sel can be loaded.
    always_comb begin
        a_fire  = a_valid && a_ready;
        b_fire  = b_valid && b_ready;
        in_fire = in_valid && in_ready;
        a_load  = in_fire && !sel;
        b_load  = in_fire && sel;
    end

    // Port A holding register. A load takes priority over the
    // emptying handshake, which allows a refill in the same cycle
    // the old word leaves. The data is held once the word is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_data  <= '0;
        end else if (a_load) begin
            a_valid <= 1'b1;
            a_data  <= in_data;
        end else if (a_fire) begin
            a_valid <= 1'b0;
        end
    end

    // Port B holding register. It behaves the same as port A.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid <= 1'b0;
            b_data  <= '0;
        end else if (b_load) begin
            b_valid <= 1'b1;
            b_data  <= in_data;
        end else if (b_fire) begin
            b_valid <= 1'b0;
        end
    end

    // Delivery counters. They increment once per output handshake and wrap modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_fire) a_count <= a_count + 1'b1;
            if (b_fire) b_count <= b_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_demux.sv
// tb_reg_demux: directed self-checking bench for reg_demux.
// Uses CNT_W=4 so that the counter wrap is reached in a few words.
module tb_reg_demux;

    localparam int SIZE  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [SIZE-1:0]  in_data;
    logic             sel;
    logic             a_valid;
    logic             a_ready;
    logic [SIZE-1:0]  a_data;
    logic [CNT_W-1:0] a_count;
    logic             b_valid;
    logic             b_ready;
    logic [SIZE-1:0]  b_data;
    logic [CNT_W-1:0] b_count;

    int checks = 0;
    int errors = 0;

    reg_demux #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .sel      (sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .a_count  (a_count),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_count  (b_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        sel      = 1'b0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;

        // Hold reset for two cycles while a word is offered.
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rst_in_ready2", {31'd0, in_ready}, 32'd0);
        chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_a_data", a_data, 32'd0);
        chk("rst_b_data", b_data, 32'd0);
        chk("rst_a_count", {28'd0, a_count}, 32'd0);
        chk("rst_b_count", {28'd0, b_count}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic routing: one word to A, then one word to B.
        in_valid = 1'b1; sel = 1'b0; in_data = 32'h00000011;
        tick();
        chk("route_a_valid", {31'd0, a_valid}, 32'd1);
        chk("route_a_data", a_data, 32'h11);
        chk("route_b_untouched", {31'd0, b_valid}, 32'd0);
        sel = 1'b1; in_data = 32'h00000022;
        tick();
        chk("route_b_data", b_data, 32'h22);
        chk("route_a_drained", {31'd0, a_valid}, 32'd0);
        chk("route_a_count", {28'd0, a_count}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("route_b_count", {28'd0, b_count}, 32'd1);
        chk("route_b_drained", {31'd0, b_valid}, 32'd0);
        chk("route_a_data_held", a_data, 32'h11);

        // Isolation: a stalled port A must not block a word bound for B.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_ready = 1'b0;
        in_valid = 1'b1; sel = 1'b0; in_data = 32'hAAAA0001;
        tick();
        chk("iso_a_data", a_data, 32'hAAAA0001);
        chk("iso_b_data_clean", b_data, 32'd0);
        in_data = 32'hAAAA0002;
        #1;
        chk("iso_backpressure", {31'd0, in_ready}, 32'd0);
        tick();
        chk("iso_a_data_held", a_data, 32'hAAAA0001);
        chk("iso_a_valid_held", {31'd0, a_valid}, 32'd1);
        sel = 1'b1;
        #1;
        chk("iso_switch_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("iso_b_data", b_data, 32'hAAAA0002);
        in_valid = 1'b0;
        tick();
        chk("iso_b_count", {28'd0, b_count}, 32'd1);
        chk("iso_a_count", {28'd0, a_count}, 32'd0);
        chk("iso_a_data_final", a_data, 32'hAAAA0001);

        // Pass-through refill: A is full, then drains and reloads in the same cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1; sel = 1'b0; in_data = 32'h1;
        tick();
        chk("refill_a_full", a_data, 32'h1);
        a_ready = 1'b1; in_data = 32'h2;
        #1;
        chk("refill_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("refill_a_valid", {31'd0, a_valid}, 32'd1);
        chk("refill_a_data", a_data, 32'h2);
        chk("refill_a_count", {28'd0, a_count}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("refill_a_empty", {31'd0, a_valid}, 32'd0);
        chk("refill_a_count2", {28'd0, a_count}, 32'd2);

        // Counter wrap: stream 17 words to B back to back. Word i-1 is delivered at edge i.
        b_ready = 1'b1; sel = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            in_data = i;
            #1;
            chk("wrap_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk("wrap_b_data", b_data, i);
            chk("wrap_b_count", {28'd0, b_count}, (i - 1) % 16);
        end
        in_valid = 1'b0;
        tick();
        chk("wrap_b_count_final", {28'd0, b_count}, 32'd1);
        chk("wrap_a_count_kept", {28'd0, a_count}, 32'd2);

        // Reset mid-operation: both ports are full and stalled.
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; sel = 1'b0; in_data = 32'h5;
        tick();
        sel = 1'b1; in_data = 32'h6;
        tick();
        chk("mid_a_full", {31'd0, a_valid}, 32'd1);
        chk("mid_b_full", {31'd0, b_valid}, 32'd1);
        rst = 1'b1; sel = 1'b0; in_data = 32'h7; a_ready = 1'b1; b_ready = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("mid_a_valid", {31'd0, a_valid}, 32'd0);
        chk("mid_b_valid", {31'd0, b_valid}, 32'd0);
        chk("mid_a_data", a_data, 32'd0);
        chk("mid_a_count", {28'd0, a_count}, 32'd0);
        chk("mid_b_count", {28'd0, b_count}, 32'd0);
        rst = 1'b0; in_data = 32'h8;
        tick();
        chk("mid_next_a_data", a_data, 32'h8);
        chk("mid_next_a_valid", {31'd0, a_valid}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("mid_next_a_count", {28'd0, a_count}, 32'd1);
        chk("mid_next_b_count", {28'd0, b_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
